dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_pick.sv | 39 +++
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int DM_ADDRESS_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between core and debug-loader requests.
// Latency: purely combinational.
// Backpressure: none; the loser simply keeps requesting.
// Ports: core_req, dbg_req (requests), last_owner (previous grant, owner_t
// encoding), winner (owner_t encoding; only meaningful when a request is up).
// Build option: DMEM_ARB_RR_EN selects round-robin, otherwise core has priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic core_req,
    input  logic dbg_req,
    input  logic last_owner,
    output logic winner
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        winner = OWN_CORE;
        if (core_req && dbg_req) begin
            // On contention, hand the memory to whoever did not have it last.
            winner = (last_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
        end else if (dbg_req) begin
            winner = OWN_DBG;
        end
    end
`else
    // Fixed priority has no use for the previous owner.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        winner = OWN_CORE;
        if (!core_req && dbg_req) begin
            winner = OWN_DBG;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (core, debug loader) arbiter in front of a single data memory.
// Latency: request sampled in IDLE at T -> gnt + memory enable at T+1 -> rvalid at T+2 (reads).
// Backpressure: one access at a time; requests outside IDLE wait (core_stall) and are held by the requester.
// Ports: clk, reset (sync, active high); core_*/dbg_* request, gnt and rvalid per requester;
// rdata shared read data; core_stall; MemRead/MemWrite/mem_addr/mem_wdata/mem_rdata to the memory.
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration with a last_owner register.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DM_ADDRESS = DM_ADDRESS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  core_gnt,
    output logic                  dbg_gnt,
    output logic                  core_rvalid,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  core_stall,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t                state_q, state_d;
    owner_t                owner_q;
    logic                  we_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;

    logic                  latch_en;
    logic                  capture_en;
    logic                  winner_bit;
    owner_t                winner;
    logic                  last_owner_bit;

`ifdef DMEM_ARB_RR_EN
    owner_t last_owner_q;

    // Resets to DBG so the core wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_DBG;
        end else if (core_gnt || dbg_gnt) begin
            last_owner_q <= owner_q;
        end
    end

    assign last_owner_bit = last_owner_q;
`else
    assign last_owner_bit = OWN_DBG;
`endif

    dmem_arb_pick u_pick (
        .core_req   (core_req),
        .dbg_req    (dbg_req),
        .last_owner (last_owner_bit),
        .winner     (winner_bit)
    );

    assign winner = owner_t'(winner_bit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        latch_en    = 1'b0;
        capture_en  = 1'b0;
        core_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        core_rvalid = 1'b0;
        dbg_rvalid  = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req || dbg_req) begin
                    latch_en = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                core_gnt = (owner_q == OWN_CORE);
                dbg_gnt  = (owner_q == OWN_DBG);
                MemWrite = we_q;
                MemRead  = !we_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    capture_en = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                core_rvalid = (owner_q == OWN_CORE);
                dbg_rvalid  = (owner_q == OWN_DBG);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Payload is latched once in IDLE so the access completes even if the
    // requester drops its request afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (latch_en) begin
                owner_q <= winner;
                if (winner == OWN_DBG) begin
                    we_q    <= dbg_we;
                    addr_q  <= dbg_addr;
                    wdata_q <= dbg_wdata;
                end else begin
                    we_q    <= core_we;
                    addr_q  <= core_addr;
                    wdata_q <= core_wdata;
                end
            end
            if (capture_en) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign rdata      = rdata_q;
    assign core_stall = core_req && !core_gnt;

endmodule
